dense_layer_engine: RTL and testbench

- Parametrised, time-multiplexed successor to the fully-parallel dense layer used in the jet-tagging MLP.
- Computes y = act(W·x + b) for one input vector per transaction. It uses PAR MAC lanes that are reused over N_OUT/PAR output groups.
- Adds three things the previous layer lacks: valid/ready handshakes with backpressure, a fused activation mode, and saturating output with a flag.
- Sits between network layers. out_valid/out_ready of one instance connect directly to in_valid/in_ready of the next.

---
 rtl/dense_layer_engine_if.sv | 25 ++
 rtl/dense_layer_engine.sv | 157 +++++++++++++++
 tb/tb_dense_layer_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_engine_if.sv
// Streaming handshake bundle for dense_layer_engine: input vector channel,
// output vector channel and the saturation side flag.
interface dense_layer_engine_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N_IN  = 16,
   parameter int unsigned N_OUT = 64
);
   logic                        in_valid;
   logic                        in_ready;
   logic [N_IN-1:0][WIDTH-1:0]  in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [N_OUT-1:0][WIDTH-1:0] out_data;
   logic                        sat_flag;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, sat_flag
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, sat_flag
   );
endinterface

// File: rtl/dense_layer_engine.sv
// Time-multiplexed dense layer y = act(W*x + b): PAR MAC lanes swept over
// N_OUT/PAR output groups, with valid/ready handshakes and saturating output.
module dense_layer_engine #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NFRAC    = 10,
   parameter int unsigned N_IN     = 16,
   parameter int unsigned N_OUT    = 64,
   parameter int unsigned PAR      = 8,
   parameter int unsigned ACT_MODE = 1,
   parameter logic [N_OUT-1:0][N_IN-1:0][WIDTH-1:0] WEIGHTS = '0,
   parameter logic [N_OUT-1:0][WIDTH-1:0]           BIAS    = '0
) (
   input logic                 clk,
   input logic                 reset_n,
   dense_layer_engine_if.slave bus
);
   localparam int unsigned G      = N_OUT / PAR;
   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(N_IN) + 1;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned G_W    = (G > 1) ? $clog2(G) : 1;
   localparam int unsigned I_W    = $clog2(N_IN + 1);
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

   if ((N_OUT % PAR) != 0) begin : g_bad_par
      $error("dense_layer_engine: N_OUT must be a multiple of PAR");
   end

   typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

   state_t                      state, state_nxt;
   logic [N_IN-1:0][WIDTH-1:0]  x_q;
   logic [G_W-1:0]              g_cnt;
   logic [I_W-1:0]              i_cnt;
   logic signed [ACC_W-1:0]     acc [PAR];
   logic [N_OUT-1:0][WIDTH-1:0] out_q;
   logic                        in_ready_q, out_valid_q, sat_flag_q, sat_acc;

   logic                        accept_c, wb_c, last_c;
   logic signed [WIDTH-1:0]     x_sel;
   logic signed [WIDTH-1:0]     w_sel [PAR];
   logic signed [WIDTH-1:0]     b_sel [PAR];
   logic signed [PROD_W-1:0]    prod  [PAR];
   logic [WIDTH-1:0]            wb_val [PAR];
   logic [PAR-1:0]              wb_sat;

   assign accept_c = bus.in_valid && in_ready_q;
   assign wb_c     = (i_cnt == I_W'(N_IN));
   assign last_c   = wb_c && (g_cnt == G_W'(G - 1));

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_q;
   assign bus.sat_flag  = sat_flag_q;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c)      state_nxt = COMPUTE;
         COMPUTE: if (last_c)        state_nxt = HOLD;
         HOLD:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Lane operand select, MAC product and writeback (bias, shift, ReLU, clamp)
   always_comb begin
      logic signed [SUM_W-1:0] sum;
      logic signed [SUM_W-1:0] r;
      sum   = '0;
      r     = '0;
      x_sel = '0;
      for (int ii = 0; ii < N_IN; ii++) begin
         if (i_cnt == I_W'(ii)) x_sel = $signed(x_q[ii]);
      end
      for (int p = 0; p < PAR; p++) begin
         w_sel[p] = '0;
         b_sel[p] = '0;
         for (int gg = 0; gg < G; gg++) begin
            if (g_cnt == G_W'(gg)) begin
               b_sel[p] = $signed(BIAS[gg*PAR+p]);
               for (int ii = 0; ii < N_IN; ii++) begin
                  if (i_cnt == I_W'(ii)) w_sel[p] = $signed(WEIGHTS[gg*PAR+p][ii]);
               end
            end
         end
         prod[p] = PROD_W'(w_sel[p]) * PROD_W'(x_sel);
         sum     = SUM_W'(acc[p]) + (SUM_W'(b_sel[p]) <<< NFRAC);
         r       = sum >>> NFRAC;
         if (ACT_MODE == 1 && r[SUM_W-1]) r = '0;
         wb_sat[p] = 1'b0;
         if (r > MAX_V) begin
            r         = MAX_V;
            wb_sat[p] = 1'b1;
         end else if (r < MIN_V) begin
            r         = MIN_V;
            wb_sat[p] = 1'b1;
         end
         wb_val[p] = WIDTH'(r);
      end
   end

   // Datapath: input latch, counters, accumulators, output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q         <= '0;
         g_cnt       <= '0;
         i_cnt       <= '0;
         out_q       <= '0;
         sat_acc     <= 1'b0;
         sat_flag_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         for (int p = 0; p < PAR; p++) acc[p] <= '0;
      end else begin
         in_ready_q  <= (state_nxt == IDLE);
         out_valid_q <= (state_nxt == HOLD);
         case (state)
            IDLE: begin
               if (accept_c) begin
                  x_q     <= bus.in_data;
                  g_cnt   <= '0;
                  i_cnt   <= '0;
                  sat_acc <= 1'b0;
                  for (int p = 0; p < PAR; p++) acc[p] <= '0;
               end
            end
            COMPUTE: begin
               if (wb_c) begin
                  for (int p = 0; p < PAR; p++) begin
                     for (int gg = 0; gg < G; gg++) begin
                        if (g_cnt == G_W'(gg)) out_q[gg*PAR+p] <= wb_val[p];
                     end
                     acc[p] <= '0;
                  end
                  i_cnt   <= '0;
                  g_cnt   <= g_cnt + G_W'(1);
                  sat_acc <= sat_acc | (|wb_sat);
                  if (last_c) sat_flag_q <= sat_acc | (|wb_sat);
               end else begin
                  for (int p = 0; p < PAR; p++) acc[p] <= acc[p] + ACC_W'(prod[p]);
                  i_cnt <= i_cnt + I_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine: four small instances (identity linear,
// identity ReLU, all-ones saturation, floor rounding) driven by hand vectors.
module tb_dense_layer_engine;
   typedef logic [3:0][15:0] vec_t;

   localparam logic [3:0][3:0][15:0] W_ID  = {64'h0400_0000_0000_0000, 64'h0000_0400_0000_0000,
                                              64'h0000_0000_0400_0000, 64'h0000_0000_0000_0400};
   localparam logic [3:0][3:0][15:0] W_ONE = {16{16'h0400}};
   localparam logic [3:0][3:0][15:0] W_FLR = 256'(16'd512);
   localparam logic [3:0][15:0]      B_FLR = 64'(16'd1024);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic in_valid [4];
   logic out_ready [4];
   vec_t in_data [4];
   logic ov [4];
   logic ir [4];
   logic sf [4];
   vec_t od [4];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   dense_layer_engine_if #(.WIDTH(16), .N_IN(4), .N_OUT(4)) if0 ();
   dense_layer_engine_if #(.WIDTH(16), .N_IN(4), .N_OUT(4)) if1 ();
   dense_layer_engine_if #(.WIDTH(16), .N_IN(4), .N_OUT(4)) if2 ();
   dense_layer_engine_if #(.WIDTH(16), .N_IN(4), .N_OUT(4)) if3 ();

   dense_layer_engine #(.WIDTH(16), .NFRAC(10), .N_IN(4), .N_OUT(4), .PAR(2), .ACT_MODE(0),
                        .WEIGHTS(W_ID), .BIAS('0))
      u_id_lin (.clk(clk), .reset_n(reset_n), .bus(if0));
   dense_layer_engine #(.WIDTH(16), .NFRAC(10), .N_IN(4), .N_OUT(4), .PAR(2), .ACT_MODE(1),
                        .WEIGHTS(W_ID), .BIAS('0))
      u_id_relu (.clk(clk), .reset_n(reset_n), .bus(if1));
   dense_layer_engine #(.WIDTH(16), .NFRAC(10), .N_IN(4), .N_OUT(4), .PAR(2), .ACT_MODE(0),
                        .WEIGHTS(W_ONE), .BIAS('0))
      u_sat (.clk(clk), .reset_n(reset_n), .bus(if2));
   dense_layer_engine #(.WIDTH(16), .NFRAC(10), .N_IN(4), .N_OUT(4), .PAR(2), .ACT_MODE(0),
                        .WEIGHTS(W_FLR), .BIAS(B_FLR))
      u_flr (.clk(clk), .reset_n(reset_n), .bus(if3));

   assign if0.in_valid = in_valid[0];  assign if0.in_data = in_data[0];  assign if0.out_ready = out_ready[0];
   assign if1.in_valid = in_valid[1];  assign if1.in_data = in_data[1];  assign if1.out_ready = out_ready[1];
   assign if2.in_valid = in_valid[2];  assign if2.in_data = in_data[2];  assign if2.out_ready = out_ready[2];
   assign if3.in_valid = in_valid[3];  assign if3.in_data = in_data[3];  assign if3.out_ready = out_ready[3];
   assign ov[0] = if0.out_valid;  assign ir[0] = if0.in_ready;  assign sf[0] = if0.sat_flag;  assign od[0] = if0.out_data;
   assign ov[1] = if1.out_valid;  assign ir[1] = if1.in_ready;  assign sf[1] = if1.sat_flag;  assign od[1] = if1.out_data;
   assign ov[2] = if2.out_valid;  assign ir[2] = if2.in_ready;  assign sf[2] = if2.sat_flag;  assign od[2] = if2.out_data;
   assign ov[3] = if3.out_valid;  assign ir[3] = if3.in_ready;  assign sf[3] = if3.sat_flag;  assign od[3] = if3.out_data;

   function automatic vec_t mk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a vector at a falling edge; returns just after the handshake edge
   task automatic start_txn(input int k, input vec_t x, input string tag);
      @(negedge clk);
      chk({tag, "_in_ready"}, 64'(ir[k]), 64'd1);
      in_valid[k] = 1'b1;
      in_data[k]  = x;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      in_data[k]  = {$urandom(), $urandom()};
   endtask

   task automatic wait_out(input int k, input vec_t exp, input logic exp_sat, input string tag);
      int lat = 0;
      while (ov[k] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd10);
      chk({tag, "_data"}, od[k], exp);
      chk({tag, "_sat"}, 64'(sf[k]), 64'(exp_sat));
   endtask

   task automatic release_out(input int k, input string tag);
      @(negedge clk);
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, 64'(ov[k]), 64'd0);
      chk({tag, "_ready_back"}, 64'(ir[k]), 64'd1);
      out_ready[k] = 1'b0;
   endtask

   initial begin
      vec_t x1, e_relu, x3, e_satp, e_satn;
      x1     = mk(1024, -2048, 512, 3072);
      e_relu = mk(1024, 0, 512, 3072);
      x3     = mk(-1024, 2048, 100, -7);
      e_satp = mk(32767, 32767, 32767, 32767);
      e_satn = mk(-32768, -32768, -32768, -32768);
      for (int k = 0; k < 4; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         in_data[k]   = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_out_data", od[0], 64'd0);
      chk("rst_sat", 64'(sf[0]), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      start_txn(0, x1, "id_lin");
      wait_out(0, x1, 1'b0, "id_lin");
      release_out(0, "id_lin");

      start_txn(1, x1, "id_relu");
      wait_out(1, e_relu, 1'b0, "id_relu");
      release_out(1, "id_relu");

      // Positive saturation held under backpressure with ignored input pulses
      start_txn(2, mk(31744, 31744, 31744, 31744), "sat_pos");
      wait_out(2, e_satp, 1'b1, "sat_pos");
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         in_valid[2] = c[0];
         in_data[2]  = {$urandom(), $urandom()};
         @(posedge clk);
         #1;
         chk("bp_data", od[2], e_satp);
         chk("bp_sat", 64'(sf[2]), 64'd1);
         chk("bp_in_ready", 64'(ir[2]), 64'd0);
         chk("bp_out_valid", 64'(ov[2]), 64'd1);
      end
      @(negedge clk);
      in_valid[2] = 1'b0;
      release_out(2, "sat_pos");

      start_txn(2, mk(-31744, -31744, -31744, -31744), "sat_neg");
      wait_out(2, e_satn, 1'b1, "sat_neg");
      release_out(2, "sat_neg");

      start_txn(3, mk(3, 0, 0, 0), "floor_pos");
      wait_out(3, mk(1025, 0, 0, 0), 1'b0, "floor_pos");
      release_out(3, "floor_pos");
      start_txn(3, mk(-3, 0, 0, 0), "floor_neg");
      wait_out(3, mk(1022, 0, 0, 0), 1'b0, "floor_neg");
      release_out(3, "floor_neg");

      // in_valid together with out_ready in HOLD: drain first, accept from IDLE
      start_txn(0, x1, "overlap_a");
      wait_out(0, x1, 1'b0, "overlap_a");
      @(negedge clk);
      in_valid[0]  = 1'b1;
      in_data[0]   = x3;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("overlap_valid_drop", 64'(ov[0]), 64'd0);
      chk("overlap_idle_ready", 64'(ir[0]), 64'd1);
      @(negedge clk);
      out_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      chk("overlap_accepted", 64'(ir[0]), 64'd0);
      wait_out(0, x3, 1'b0, "overlap_b");
      release_out(0, "overlap_b");

      // Reset in the middle of COMPUTE, after group 0 has been written back
      start_txn(0, x3, "abort");
      repeat (5) @(posedge clk);
      #1;
      chk("abort_group0_visible", 64'(od[0][1:0]), 64'(x3[1:0]));
      chk("abort_no_valid", 64'(ov[0]), 64'd0);
      reset_n = 1'b0;
      #1;
      chk("abort_in_ready", 64'(ir[0]), 64'd1);
      chk("abort_out_valid", 64'(ov[0]), 64'd0);
      chk("abort_out_data", od[0], 64'd0);
      chk("abort_sat", 64'(sf[0]), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      start_txn(0, x1, "post_rst");
      wait_out(0, x1, 1'b0, "post_rst");
      release_out(0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
